// File: rtl/saturn_bus_initiator.sv
// -----------------------------------------------------------------------------
// saturn_bus_initiator
//
// Controller end of the Saturn nibble bus. Converts one CPU transaction request
// into the nibble sequence the daisy-chained RAM/ROM/IO slaves decode: a command
// nibble, optional LOAD address nibbles, then data nibbles. Shadow copies of the
// slaves' PC and DP pointers let the initiator skip a LOAD whenever the slaves
// already point at the requested address.
//
// Ports
//   i_clk, i_reset_n    clock, asynchronous active-low reset
//   i_clk_en            bus slot strobe; at most one bus nibble per strobe
//   i_req_valid/o_req_ready, i_req_op/addr/len/wdata   request handshake
//   o_rsp_valid         one-cycle completion pulse
//   o_rsp_rdata         read nibbles packed LSB first, unused nibbles zero
//   o_bus_clk_en        a nibble is on the bus this cycle
//   o_bus_is_data       0 = command nibble, 1 = address/data nibble
//   o_bus_nibble_out    nibble driven to the slaves
//   i_bus_nibble_in     nibble returned by the active slave (slave-registered)
//
// Bus command nibble values
//   0 PC_READ, 1 DP_READ, 2 PC_WRITE, 3 DP_WRITE, 4 LOAD_PC, 5 LOAD_DP,
//   6 CONFIGURE, A RESET
// -----------------------------------------------------------------------------
module saturn_bus_initiator (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [19:0] i_req_addr,
  input  logic [3:0]  i_req_len,
  input  logic [63:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_rdata,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in
);

  localparam logic [3:0] BUSCMD_PC_READ   = 4'h0;
  localparam logic [3:0] BUSCMD_DP_READ   = 4'h1;
  localparam logic [3:0] BUSCMD_PC_WRITE  = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h5;
  localparam logic [3:0] BUSCMD_CONFIGURE = 4'h6;
  localparam logic [3:0] BUSCMD_RESET     = 4'hA;

  localparam logic [2:0] OP_CONFIGURE = 3'd4;
  localparam logic [2:0] OP_RESET     = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_CMD,
    S_ADDR,
    S_ACC_CMD,
    S_DATA,
    S_RD_TAIL,
    S_CFG_CMD,
    S_RST_CMD,
    S_RESP
  } state_t;

  state_t      state, state_nx;

  // Latched request
  logic [2:0]  op_q;
  logic [19:0] addr_q;
  logic [3:0]  len_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;

  // Slot counter: address nibble index in ADDR, data nibble index in DATA
  logic [3:0]  cnt;
  logic [3:0]  cnt_prev;

  // Shadow copies of the slaves' pointers
  logic [19:0] pc_shadow, dp_shadow;
  logic        pc_valid, dp_valid;

  logic        req_hit;
  logic        op_is_rw, op_is_read, op_is_dp;
  logic        last_addr, last_data;
  logic        bus_slot;

  // Ops 0..3 are memory accesses; bit 0 selects DP, bit 1 selects write.
  always_comb begin
    req_hit    = i_req_op[0] ? (dp_valid && (dp_shadow == i_req_addr))
                             : (pc_valid && (pc_shadow == i_req_addr));
    op_is_rw   = ~op_q[2];
    op_is_read = (op_q[2:1] == 2'b00);
    op_is_dp   = op_q[0];
    last_addr  = (cnt == 4'd4);
    last_data  = (cnt == len_q);
    cnt_prev   = cnt - 4'd1;
  end

  // Gated with the reset pin so the handshake stays low while reset is held.
  assign o_req_ready = (state == S_IDLE) && i_reset_n;
  assign o_rsp_valid = (state == S_RESP);
  assign o_rsp_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Next-state logic. Every bus state advances only on a slot strobe, so a gap
  // in i_clk_en simply freezes the sequence.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (!i_req_op[2])                 state_nx = req_hit ? S_ACC_CMD : S_LD_CMD;
          else if (i_req_op == OP_CONFIGURE) state_nx = S_CFG_CMD;
          else if (i_req_op == OP_RESET)     state_nx = S_RST_CMD;
          else                               state_nx = S_RESP;
        end
      end
      S_LD_CMD:  if (i_clk_en) state_nx = S_ADDR;
      S_CFG_CMD: if (i_clk_en) state_nx = S_ADDR;
      S_ADDR: begin
        // After a LOAD the slave switches to *_READ on its own, so reads need
        // no further command; writes must still issue the write command.
        if (i_clk_en && last_addr) begin
          if (!op_is_rw)       state_nx = S_RESP;
          else if (op_is_read) state_nx = S_DATA;
          else                 state_nx = S_ACC_CMD;
        end
      end
      S_ACC_CMD: if (i_clk_en) state_nx = S_DATA;
      S_DATA: begin
        if (i_clk_en && last_data) state_nx = op_is_read ? S_RD_TAIL : S_RESP;
      end
      S_RD_TAIL: if (i_clk_en) state_nx = S_RESP;
      S_RST_CMD: if (i_clk_en) state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus drive. Nibble and is_data are decoded from registered state only; the
  // strobe is qualified by i_clk_en so a slot always lines up with a bus slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_slot         = 1'b0;
    o_bus_is_data    = 1'b0;
    o_bus_nibble_out = 4'h0;
    case (state)
      S_LD_CMD: begin
        bus_slot         = 1'b1;
        o_bus_nibble_out = op_is_dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
      end
      S_CFG_CMD: begin
        bus_slot         = 1'b1;
        o_bus_nibble_out = BUSCMD_CONFIGURE;
      end
      S_RST_CMD: begin
        bus_slot         = 1'b1;
        o_bus_nibble_out = BUSCMD_RESET;
      end
      S_ACC_CMD: begin
        bus_slot = 1'b1;
        case (op_q[1:0])
          2'b00:   o_bus_nibble_out = BUSCMD_PC_READ;
          2'b01:   o_bus_nibble_out = BUSCMD_DP_READ;
          2'b10:   o_bus_nibble_out = BUSCMD_PC_WRITE;
          default: o_bus_nibble_out = BUSCMD_DP_WRITE;
        endcase
      end
      S_ADDR: begin
        bus_slot      = 1'b1;
        o_bus_is_data = 1'b1;
        case (cnt[2:0])
          3'd0:    o_bus_nibble_out = addr_q[3:0];
          3'd1:    o_bus_nibble_out = addr_q[7:4];
          3'd2:    o_bus_nibble_out = addr_q[11:8];
          3'd3:    o_bus_nibble_out = addr_q[15:12];
          default: o_bus_nibble_out = addr_q[19:16];
        endcase
      end
      S_DATA: begin
        bus_slot         = 1'b1;
        o_bus_is_data    = 1'b1;
        o_bus_nibble_out = op_is_read ? 4'h0 : wdata_q[{cnt, 2'b00} +: 4];
      end
      default: ;
    endcase
    o_bus_clk_en = bus_slot && i_clk_en;
  end

  // ---------------------------------------------------------------------------
  // State, request latch, read capture and shadow pointers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      op_q      <= 3'd0;
      addr_q    <= 20'd0;
      len_q     <= 4'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      cnt       <= 4'd0;
      pc_shadow <= 20'd0;
      dp_shadow <= 20'd0;
      pc_valid  <= 1'b0;
      dp_valid  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            op_q    <= i_req_op;
            addr_q  <= i_req_addr;
            len_q   <= i_req_len;
            wdata_q <= i_req_wdata;
            cnt     <= 4'd0;
            if (i_req_op[2:1] == 2'b00) rdata_q <= 64'd0;
          end
        end
        S_ADDR: begin
          if (i_clk_en) begin
            cnt <= last_addr ? 4'd0 : cnt + 4'd1;
            // A completed LOAD leaves the slave pointer at the address.
            if (last_addr && op_is_rw) begin
              if (op_is_dp) begin
                dp_shadow <= addr_q;
                dp_valid  <= 1'b1;
              end else begin
                pc_shadow <= addr_q;
                pc_valid  <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (i_clk_en) begin
            // The slave registers its read nibble, so slot k returns nibble k-1.
            if (op_is_read && (cnt != 4'd0)) rdata_q[{cnt_prev, 2'b00} +: 4] <= i_bus_nibble_in;
            cnt <= last_data ? 4'd0 : cnt + 4'd1;
            // Slave pointers auto-increment once per data nibble, wrapping at 20 bits.
            if (last_data) begin
              if (op_is_dp) dp_shadow <= dp_shadow + {16'd0, len_q} + 20'd1;
              else          pc_shadow <= pc_shadow + {16'd0, len_q} + 20'd1;
            end
          end
        end
        S_RD_TAIL: begin
          if (i_clk_en) rdata_q[{len_q, 2'b00} +: 4] <= i_bus_nibble_in;
        end
        S_RST_CMD: begin
          if (i_clk_en) begin
            pc_valid <= 1'b0;
            dp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
